dot_acc_collector: RTL and testbench

Result-side companion to the 8-lane `baseline` MAC datapath. It gates operand issue into `baseline` with a valid/ready handshake and tracks each accepted beat through the datapath's fixed latency. It reduces the two partial sums `out_o[0] + out_o[1]` and accumulates them over a group of beats ended by a last flag. Finished group results are delivered through a small FIFO with a valid/ready output handshake.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/dot_acc_fifo.sv | 56 +++++
 rtl/dot_acc_collector.sv | 129 ++++++++++++
 tb/tb_dot_acc_collector.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared width helpers, result record and saturating adder for the MAC result path.
package mac_pkg;

    function automatic int psum_w(input int in_size_0, input int in_size_1);
        return in_size_0 + in_size_1 + 8;
    endfunction

    localparam int ACC_W_DEF = psum_w(4, 8) + 8;
    localparam int SAT_W     = 64;

    typedef struct packed {
        logic                        ovf;
        logic signed [ACC_W_DEF-1:0] data;
    } res_t;

    // Adds at full 64-bit precision and clamps to a w-bit signed range; MSB of the result is the clamp flag.
    function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int                      w);
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return {1'b1, hi};
        end else if (s < lo) begin
            return {1'b1, lo};
        end
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/dot_acc_fifo.sv
// Small result FIFO; head is zero while empty and count drives upstream credit logic.
module dot_acc_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop_i && (r_count != '0);
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid_o = (r_count != '0);
    assign head_o  = valid_o ? r_mem[r_rd] : '0;
    assign count_o = r_count;

endmodule

// File: rtl/dot_acc_collector.sv
// Issues beats into the fixed-latency MAC datapath, reduces and accumulates the returning
// partial sums per group, and queues saturated group results behind a credit-gated FIFO.
module dot_acc_collector
    import mac_pkg::*;
#(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int PSUM_W    = psum_w(IN_SIZE_0, IN_SIZE_1),
    parameter int ACC_W     = PSUM_W + 8,
    parameter int LAT       = 3,
    parameter int DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    input  logic                       in_last_i,
    output logic                       in_ready_o,
    input  logic [2*PSUM_W-1:0]        psum_i,
    output logic signed [ACC_W-1:0]    res_data_o,
    output logic                       res_ovf_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic                       busy_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;
    localparam int         CW      = $clog2(DEPTH) + 1;

    logic [LAT-1:0]          r_sr_valid;
    logic [LAT-1:0]          r_sr_last;
    logic [0:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;

    logic                    w_accept;
    logic                    w_arrive;
    logic                    w_arr_last;
    int                      w_n_last;
    logic [CW-1:0]           w_fifo_count;
    logic signed [PSUM_W-1:0] w_p0;
    logic signed [PSUM_W-1:0] w_p1;
    logic signed [SAT_W-1:0] w_sum;
    logic signed [SAT_W-1:0] w_base;
    logic [SAT_W:0]          w_sat;
    logic [ACC_W-1:0]        w_acc_next;
    logic [SAT_W-1:ACC_W]    w_unused_hi;
    logic                    w_ovf_next;
    logic                    w_push;
    logic                    w_pop;
    logic [ACC_W:0]          w_head;

    assign w_accept   = in_valid_i && in_ready_o;
    assign w_arrive   = r_sr_valid[LAT-1];
    assign w_arr_last = r_sr_last[LAT-1];

    // Each in-flight last beat already owns a FIFO slot, so a push can never find the FIFO full.
    always_comb begin
        w_n_last = 0;
        for (int i = 0; i < LAT; i++) begin
            if (r_sr_valid[i] && r_sr_last[i]) w_n_last = w_n_last + 1;
        end
    end
    assign in_ready_o = (int'(w_fifo_count) + w_n_last) < DEPTH;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sr_valid <= '0;
            r_sr_last  <= '0;
        end else begin
            r_sr_valid[0] <= w_accept;
            r_sr_last[0]  <= w_accept && in_last_i;
            for (int i = 1; i < LAT; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
                r_sr_last[i]  <= r_sr_last[i-1];
            end
        end
    end

    assign w_p0   = psum_i[PSUM_W-1:0];
    assign w_p1   = psum_i[2*PSUM_W-1:PSUM_W];
    assign w_sum  = {{(SAT_W-PSUM_W){w_p0[PSUM_W-1]}}, w_p0}
                  + {{(SAT_W-PSUM_W){w_p1[PSUM_W-1]}}, w_p1};
    assign w_base = (r_state == ST_OPEN) ? {{(SAT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc} : '0;
    assign w_sat  = sat_add(w_base, w_sum, ACC_W);

    assign w_acc_next  = w_sat[ACC_W-1:0];
    assign w_unused_hi = w_sat[SAT_W-1:ACC_W];
    assign w_ovf_next  = ((r_state == ST_OPEN) && r_ovf) || w_sat[SAT_W];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_arrive) begin
            if (w_arr_last) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_state <= ST_OPEN;
                r_acc   <= w_acc_next;
                r_ovf   <= w_ovf_next;
            end
        end
    end

    assign w_push = w_arrive && w_arr_last;
    assign w_pop  = res_valid_o && res_ready_i;

    dot_acc_fifo #(
        .W     (ACC_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i ({w_ovf_next, w_acc_next}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .valid_o     (res_valid_o),
        .count_o     (w_fifo_count)
    );

    assign res_data_o = w_head[ACC_W-1:0];
    assign res_ovf_o  = w_head[ACC_W];
    assign busy_o     = (r_state == ST_OPEN) || (|r_sr_valid);

endmodule

// File: tb/tb_dot_acc_collector.sv
// Directed bench for dot_acc_collector: default instance plus an ACC_W=21 instance for saturation.
module tb_dot_acc_collector;
    localparam int LAT    = 3;
    localparam int PSUM_W = 20;
    localparam int ACC_WA = 28;
    localparam int ACC_WB = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     valid_a, last_a, ready_a, res_ready_a, ovf_a, res_valid_a, busy_a;
    logic [2*PSUM_W-1:0]      psum_a;
    logic signed [ACC_WA-1:0] data_a;
    logic                     valid_b, last_b, ready_b, res_ready_b, ovf_b, res_valid_b, busy_b;
    logic [2*PSUM_W-1:0]      psum_b;
    logic signed [ACC_WB-1:0] data_b;

    logic [ACC_WA:0] exp_qa[$];
    logic [ACC_WB:0] exp_qb[$];
    logic [2*PSUM_W-1:0] map_a[int];
    logic [2*PSUM_W-1:0] map_b[int];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    dot_acc_collector u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(valid_a), .in_last_i(last_a),
        .in_ready_o(ready_a), .psum_i(psum_a), .res_data_o(data_a), .res_ovf_o(ovf_a),
        .res_valid_o(res_valid_a), .res_ready_i(res_ready_a), .busy_o(busy_a)
    );

    dot_acc_collector #(.ACC_W(ACC_WB)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(valid_b), .in_last_i(last_b),
        .in_ready_o(ready_b), .psum_i(psum_b), .res_data_o(data_b), .res_ovf_o(ovf_b),
        .res_valid_o(res_valid_b), .res_ready_i(res_ready_b), .busy_o(busy_b)
    );

    // Partial sums appear just before the sample edge of their beat; garbage otherwise.
    always @(posedge clk) begin
        cyc++;
        #1;
        psum_a = map_a.exists(cyc + 1) ? map_a[cyc + 1] : 40'({$urandom(), $urandom()});
        psum_b = map_b.exists(cyc + 1) ? map_b[cyc + 1] : 40'({$urandom(), $urandom()});
    end

    function automatic logic [ACC_WA:0] mk_a(input bit o, input int d);
        logic [ACC_WA-1:0] dd;
        dd = d[ACC_WA-1:0];
        return {o, dd};
    endfunction

    function automatic logic [ACC_WB:0] mk_b(input bit o, input int d);
        logic [ACC_WB-1:0] dd;
        dd = d[ACC_WB-1:0];
        return {o, dd};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic issue(input bit sel, input bit last, input int p0, input int p1);
        int t;
        logic [2*PSUM_W-1:0] pv;
        pv = {p1[PSUM_W-1:0], p0[PSUM_W-1:0]};
        t = 0;
        if (sel) begin valid_b = 1'b1; last_b = last; end
        else     begin valid_a = 1'b1; last_a = last; end
        while (!(sel ? ready_b : ready_a) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready_o stayed 0 for %0d cycles", t);
        end else begin
            if (sel) map_b[cyc + 1 + LAT] = pv;
            else     map_a[cyc + 1 + LAT] = pv;
            @(posedge clk); #1;
        end
        valid_a = 1'b0; last_a = 1'b0;
        valid_b = 1'b0; last_b = 1'b0;
    endtask

    task automatic wait_drain(input bit sel);
        int t;
        t = 0;
        while (((sel ? exp_qb.size() : exp_qa.size()) != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(sel ? "drain_b" : "drain_a", sel ? exp_qb.size() : exp_qa.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [ACC_WA:0] ea;
        logic [ACC_WB:0] eb;
        if (res_valid_a && res_ready_a) begin
            n_tests++;
            if (exp_qa.size() == 0) begin
                n_fail++;
                $display("FAIL res_a_unexpected: got %h required no result", {ovf_a, data_a});
            end else begin
                ea = exp_qa.pop_front();
                if ({ovf_a, data_a} !== ea) begin
                    n_fail++;
                    $display("FAIL res_a: got %h required %h", {ovf_a, data_a}, ea);
                end
            end
        end
        if (res_valid_b && res_ready_b) begin
            n_tests++;
            if (exp_qb.size() == 0) begin
                n_fail++;
                $display("FAIL res_b_unexpected: got %h required no result", {ovf_b, data_b});
            end else begin
                eb = exp_qb.pop_front();
                if ({ovf_b, data_b} !== eb) begin
                    n_fail++;
                    $display("FAIL res_b: got %h required %h", {ovf_b, data_b}, eb);
                end
            end
        end
    end

    initial begin
        valid_a = 0; last_a = 0; res_ready_a = 1; psum_a = '0;
        valid_b = 0; last_b = 0; res_ready_b = 1; psum_b = '0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ready_a, 1);
        chk("rst_res_valid", res_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_res_data", data_a, 0);
        chk("rst_res_ovf", ovf_a, 0);
        rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_no_write", res_valid_a, 0);
        chk("idle_busy", busy_a, 0);

        // single-beat group, held to check latency and stability
        res_ready_a = 0;
        exp_qa.push_back(mk_a(1'b0, 70));
        issue(1'b0, 1'b1, 100, -30);
        repeat (2) @(posedge clk);
        #1;
        chk("single_not_yet", res_valid_a, 0);
        @(posedge clk); #1;
        chk("single_valid", res_valid_a, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("single_hold_valid", res_valid_a, 1);
        chk("single_hold_data", data_a, 70);
        res_ready_a = 1;
        wait_drain(1'b0);

        // three-beat group
        exp_qa.push_back(mk_a(1'b0, -6));
        issue(1'b0, 1'b0, 5, 5);
        chk("group_busy_open", busy_a, 1);
        issue(1'b0, 1'b0, -20, 3);
        issue(1'b0, 1'b1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("group_busy_flight", busy_a, 1);
        chk("group_not_yet", res_valid_a, 0);
        @(posedge clk); #1;
        chk("group_valid", res_valid_a, 1);
        chk("group_busy_done", busy_a, 0);
        wait_drain(1'b0);

        // backpressure with six single-beat groups
        res_ready_a = 0;
        for (int i = 1; i <= 6; i++) exp_qa.push_back(mk_a(1'b0, 11 * i));
        for (int i = 1; i <= 4; i++) issue(1'b0, 1'b1, 10 * i, i);
        chk("bp_ready_drop", ready_a, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_ready_full", ready_a, 0);
        chk("bp_valid_full", res_valid_a, 1);
        chk("bp_head_first", data_a, 11);
        res_ready_a = 1;
        for (int i = 5; i <= 6; i++) issue(1'b0, 1'b1, 10 * i, i);
        wait_drain(1'b0);
        chk("bp_ready_restored", ready_a, 1);

        // saturation on the narrow instance
        exp_qb.push_back(mk_b(1'b1, 1048575));
        issue(1'b1, 1'b0, 524287, 524287);
        issue(1'b1, 1'b1, 524287, 524287);
        exp_qb.push_back(mk_b(1'b0, -1));
        issue(1'b1, 1'b1, -1, 0);
        wait_drain(1'b1);

        // reset while a last beat is in flight
        issue(1'b0, 1'b1, 50, 50);
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_valid", res_valid_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_ready", ready_a, 1);
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", res_valid_a, 0);
        exp_qa.push_back(mk_a(1'b0, 0));
        issue(1'b0, 1'b1, 7, -7);
        wait_drain(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("end_valid_a", res_valid_a, 0);
        chk("end_valid_b", res_valid_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
